// File: rtl/smem_port_arbiter_if.sv
// Bundles the two requester ports, the local-memory bank port and busy into
// one interface; the arbiter takes the slave view, its environment the master.
interface smem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8
);
    logic [1:0]              req_valid;
    logic [1:0]              req_rw;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [2*DATA_WIDTH-1:0] req_data;
    logic [2*TAG_WIDTH-1:0]  req_tag;
    logic [1:0]              req_ready;
    logic [1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [TAG_WIDTH-1:0]    rsp_tag;
    logic [1:0]              rsp_ready;
    logic                    mem_req_valid;
    logic                    mem_req_rw;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic [DATA_WIDTH-1:0]   mem_req_data;
    logic [TAG_WIDTH:0]      mem_req_tag;
    logic                    mem_req_ready;
    logic                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]   mem_rsp_data;
    logic [TAG_WIDTH:0]      mem_rsp_tag;
    logic                    mem_rsp_ready;
    logic                    busy;

    // Every channel is valid/ready: a transfer happens in the cycle where both
    // are high; valid must not wait on ready, and ready may depend on valid.
    modport slave (
        input  req_valid, req_rw, req_addr, req_data, req_tag, rsp_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output req_ready, rsp_valid, rsp_data, rsp_tag, mem_req_valid,
               mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
               mem_rsp_ready, busy
    );

    modport master (
        output req_valid, req_rw, req_addr, req_data, req_tag, rsp_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, mem_req_valid,
               mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
               mem_rsp_ready, busy
    );
endinterface

// File: rtl/smem_port_arbiter.sv
// Round-robin arbiter sharing one local-memory port between the LSU (0) and
// the DXA fill path (1), with per-requester read throttling and tag routing.
module smem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 4,
    localparam int CW = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    smem_port_arbiter_if.slave   bus,
    output logic [1:0][CW-1:0]   dbg_pend_o
);
    localparam logic [CW-1:0] MAXP = CW'(MAX_PENDING);

    logic                  valid_q, valid_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TAG_WIDTH:0]    tag_q, tag_d;
    logic                  pri_q, pri_d;
    logic [1:0][CW-1:0]    pend_q, pend_d;

    logic       can_load;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       gsel;
    logic       sel;
    logic       rsp_fire;
    logic       inc;
    logic       dec;

    assign can_load = !valid_q || bus.mem_req_ready;
    assign sel      = bus.mem_rsp_tag[TAG_WIDTH];
    assign rsp_fire = bus.mem_rsp_valid && bus.mem_rsp_ready;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eligible[i] = bus.req_valid[i] && (bus.req_rw[i] || pend_q[i] < MAXP);
        end
        // pri_q names the requester that wins a tie: the one not granted last.
        if (&eligible) grant = pri_q ? 2'b10 : 2'b01;
        else           grant = eligible;
        gsel = grant[1];
    end

    always_comb begin
        valid_d = valid_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tag_d   = tag_q;
        pri_d   = pri_q;
        if (can_load) begin
            valid_d = |grant;
            if (|grant) begin
                rw_d   = bus.req_rw[gsel];
                addr_d = bus.req_addr[gsel*ADDR_WIDTH +: ADDR_WIDTH];
                data_d = bus.req_data[gsel*DATA_WIDTH +: DATA_WIDTH];
                tag_d  = {gsel, bus.req_tag[gsel*TAG_WIDTH +: TAG_WIDTH]};
                pri_d  = ~gsel;
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < 2; i++) begin
            inc = can_load && grant[i] && !bus.req_rw[i];
            dec = rsp_fire && (sel == 1'(i));
            // A stray response at zero is delivered but must not wrap the count.
            if (inc && !dec)                        pend_d[i] = pend_q[i] + CW'(1);
            else if (dec && !inc && pend_q[i] != '0) pend_d[i] = pend_q[i] - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            pri_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            pri_q   <= pri_d;
            pend_q  <= pend_d;
        end
    end

    always @(posedge clk) begin
        if (reset && rsp_fire) begin
            a_no_underflow: assert (pend_q[sel] != '0);
        end
    end

    assign bus.req_ready     = can_load ? grant : 2'b00;
    assign bus.mem_req_valid = valid_q;
    assign bus.mem_req_rw    = rw_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_data  = data_q;
    assign bus.mem_req_tag   = tag_q;

    assign bus.rsp_valid     = sel ? {bus.mem_rsp_valid, 1'b0} : {1'b0, bus.mem_rsp_valid};
    assign bus.rsp_data      = bus.mem_rsp_data;
    assign bus.rsp_tag       = bus.mem_rsp_tag[TAG_WIDTH-1:0];
    assign bus.mem_rsp_ready = bus.rsp_ready[sel];

    assign bus.busy   = valid_q || pend_q[0] != '0 || pend_q[1] != '0;
    assign dbg_pend_o = pend_q;
endmodule

// File: tb/tb_smem_port_arbiter.sv
// Directed bench for smem_port_arbiter: expected downstream packets are queued
// at grant time and checked when they leave the output register.
module tb_smem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int MP = 4;
    localparam int CW = $clog2(MP + 1);
    localparam int PW = 1 + AW + DW + TW + 1;

    logic clk;
    logic reset;
    logic [1:0][CW-1:0] dbg_pend;

    smem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    smem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .dbg_pend_o(dbg_pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [PW-1:0] exp_q[$];
    logic exp_mv = 1'b0;

    task automatic chk(input logic [127:0] got, input logic [127:0] exp, input string nm);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic rw);
        bus.req_valid[i]           = v;
        bus.req_rw[i]              = rw;
        bus.req_addr[i*AW +: AW]   = AW'($urandom);
        bus.req_data[i*DW +: DW]   = DW'($urandom);
        bus.req_tag[i*TW +: TW]    = TW'($urandom_range(0, 255));
    endtask

    task automatic set_rsp(input logic v, input logic s, input logic [TW-1:0] t);
        bus.mem_rsp_valid = v;
        bus.mem_rsp_tag   = {s, t};
        bus.mem_rsp_data  = DW'($urandom);
    endtask

    task automatic tick(input logic [1:0] er, input logic [1:0] erv, input logic emrr,
                        input string nm);
        logic [PW-1:0] pkt;
        @(negedge clk);
        chk(bus.mem_req_valid, exp_mv, {nm, "/mem_req_valid"});
        if (exp_mv) begin
            if (exp_q.size() == 0) begin
                chk(1, 0, {nm, "/queue_empty"});
            end else begin
                if (bus.mem_req_ready) pkt = exp_q.pop_front();
                else                   pkt = exp_q[0];
                chk({bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_data, bus.mem_req_tag},
                    pkt, {nm, "/mem_req_pkt"});
            end
        end
        chk(bus.req_ready, er, {nm, "/req_ready"});
        chk(bus.rsp_valid, erv, {nm, "/rsp_valid"});
        if (erv != 2'b00) begin
            chk(bus.rsp_data, bus.mem_rsp_data, {nm, "/rsp_data"});
            chk(bus.rsp_tag, bus.mem_rsp_tag[TW-1:0], {nm, "/rsp_tag"});
            chk(bus.mem_rsp_ready, emrr, {nm, "/mem_rsp_ready"});
        end
        for (int i = 0; i < 2; i++) begin
            if (er[i]) exp_q.push_back({bus.req_rw[i], bus.req_addr[i*AW +: AW],
                                        bus.req_data[i*DW +: DW], 1'(i),
                                        bus.req_tag[i*TW +: TW]});
        end
        exp_mv = (er != 2'b00) || (exp_mv && !bus.mem_req_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_valid = 2'b00;
        bus.req_rw    = 2'b00;
    endtask

    initial begin
        reset = 1'b0;
        bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.req_tag = '0; bus.rsp_ready = '0; bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0; bus.mem_rsp_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk(bus.mem_req_valid, 0, "rst/mem_req_valid");
        chk(bus.mem_req_addr, 0, "rst/mem_req_addr");
        chk(bus.mem_req_tag, 0, "rst/mem_req_tag");
        chk(dbg_pend, 0, "rst/pend");
        chk(bus.busy, 0, "rst/busy");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk(bus.busy, 0, "rst_rel/busy");

        // Both requesters reading continuously: strict alternation from 0.
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 1'b0);
            set_req(1, 1'b1, 1'b0);
            tick((k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 1'b0, "rr_alt");
        end
        clear_reqs();
        tick(2'b00, 2'b00, 1'b0, "rr_drain");
        chk(dbg_pend, {3'd2, 3'd2}, "rr/pend");
        chk(bus.busy, 1, "rr/busy");

        bus.rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            set_rsp(1'b1, 1'(k % 2), TW'($urandom_range(0, 255)));
            tick(2'b00, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1, "rsp_drain");
        end
        set_rsp(1'b0, 1'b0, 8'h00);
        chk(dbg_pend, 0, "rsp_drain/pend");
        chk(bus.busy, 0, "rsp_drain/busy");

        // Requester 0 fills its pending budget; reads stall, writes pass.
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 1'b0);
            tick(2'b01, 2'b00, 1'b0, "cap_fill");
        end
        set_req(0, 1'b1, 1'b0);
        tick(2'b00, 2'b00, 1'b0, "cap_hold");
        chk(dbg_pend, {3'd0, 3'd4}, "cap/pend");
        set_req(0, 1'b1, 1'b1);
        tick(2'b01, 2'b00, 1'b0, "cap_write");
        chk(dbg_pend, {3'd0, 3'd4}, "cap_write/pend");
        set_req(0, 1'b1, 1'b0);
        set_rsp(1'b1, 1'b0, 8'h11);
        tick(2'b00, 2'b01, 1'b1, "cap_rsp");
        chk(dbg_pend, {3'd0, 3'd3}, "cap_rsp/pend");
        set_rsp(1'b0, 1'b0, 8'h00);
        set_req(0, 1'b1, 1'b0);
        tick(2'b01, 2'b00, 1'b0, "cap_regrant");
        chk(dbg_pend, {3'd0, 3'd4}, "cap_regrant/pend");

        // Downstream backpressure with the register full.
        clear_reqs();
        set_req(1, 1'b1, 1'b0);
        bus.mem_req_ready = 1'b0;
        repeat (3) tick(2'b00, 2'b00, 1'b0, "stall");
        bus.mem_req_ready = 1'b1;
        tick(2'b10, 2'b00, 1'b0, "stall_release");
        clear_reqs();
        tick(2'b00, 2'b00, 1'b0, "stall_drain");
        chk(dbg_pend, {3'd1, 3'd4}, "stall/pend");

        // Response backpressure on requester 1.
        set_rsp(1'b1, 1'b1, 8'h5A);
        bus.rsp_ready = 2'b01;
        tick(2'b00, 2'b10, 1'b0, "rsp_bp");
        chk(dbg_pend, {3'd1, 3'd4}, "rsp_bp/pend");
        bus.rsp_ready = 2'b11;
        tick(2'b00, 2'b10, 1'b1, "rsp_fire");
        set_rsp(1'b0, 1'b0, 8'h00);
        chk(dbg_pend, {3'd0, 3'd4}, "rsp_fire/pend");

        // Same-cycle read grant and response for requester 1.
        set_req(1, 1'b1, 1'b0);
        tick(2'b10, 2'b00, 1'b0, "same_pre");
        set_req(1, 1'b1, 1'b0);
        set_rsp(1'b1, 1'b1, TW'($urandom_range(0, 255)));
        tick(2'b10, 2'b10, 1'b1, "same");
        set_rsp(1'b0, 1'b0, 8'h00);
        chk(dbg_pend, {3'd1, 3'd4}, "same/pend");
        chk(bus.busy, 1, "same/busy");

        // Build pend={1:3, 0:2} with the register full, then reset mid-cycle.
        for (int k = 0; k < 2; k++) begin
            set_req(1, 1'b1, 1'b0);
            set_rsp(1'b1, 1'b0, TW'($urandom_range(0, 255)));
            tick(2'b10, 2'b01, 1'b1, "pre_rst");
        end
        clear_reqs();
        set_rsp(1'b0, 1'b0, 8'h00);
        chk(dbg_pend, {3'd3, 3'd2}, "pre_rst/pend");
        chk(bus.mem_req_valid, 1, "pre_rst/mem_req_valid");
        #2;
        reset = 1'b0;
        #1;
        chk(bus.mem_req_valid, 0, "async_rst/mem_req_valid");
        chk(dbg_pend, 0, "async_rst/pend");
        chk(bus.busy, 0, "async_rst/busy");
        exp_q.delete();
        exp_mv = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Pointer favours requester 0 again after reset.
        set_req(0, 1'b1, 1'b0);
        set_req(1, 1'b1, 1'b0);
        tick(2'b01, 2'b00, 1'b0, "rr_post_rst0");
        set_req(0, 1'b1, 1'b0);
        set_req(1, 1'b1, 1'b0);
        tick(2'b10, 2'b00, 1'b0, "rr_post_rst1");
        clear_reqs();
        tick(2'b00, 2'b00, 1'b0, "final_drain");
        chk(exp_q.size(), 0, "final/queue_left");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/smem_port_arbiter.md
Name: smem_port_arbiter

Overview:
- Shares the core's single local-memory port between two requesters: the LSU local-memory path (requester 0) and the DXA shared-memory fill path (requester 1).
- Sits between those requesters and the local-memory bank.
- Arbitrates round-robin and tags each granted request with its requester index.
- Limits outstanding reads per requester and routes responses back by tag.
- Requests leave through a one-entry output register.

Parameters:
ADDR_WIDTH, 32, word address width
DATA_WIDTH, 32, request/response data width
TAG_WIDTH, 8, requester tag width; downstream tag is TAG_WIDTH+1
MAX_PENDING, 4, maximum outstanding reads per requester (>=1)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
req_valid  in  2  request valid, one bit per requester
req_rw  in  2  1=write, 0=read
req_addr  in  2*ADDR_WIDTH  address, requester i at slice i
req_data  in  2*DATA_WIDTH  write data
req_tag  in  2*TAG_WIDTH  requester tag
req_ready  out  2  request accepted when valid&&ready
rsp_valid  out  2  response valid per requester
rsp_data  out  DATA_WIDTH  response data, shared bus
rsp_tag  out  TAG_WIDTH  original requester tag
rsp_ready  in  2  requester can accept a response
mem_req_valid  out  1  downstream request valid
mem_req_rw  out  1  downstream rw
mem_req_addr  out  ADDR_WIDTH  downstream address
mem_req_data  out  DATA_WIDTH  downstream write data
mem_req_tag  out  TAG_WIDTH+1  {requester index, requester tag}
mem_req_ready  in  1  downstream accepts request
mem_rsp_valid  in  1  read response valid
mem_rsp_data  in  DATA_WIDTH  read data
mem_rsp_tag  in  TAG_WIDTH+1  returned tag
mem_rsp_ready  out  1  arbiter accepts response
busy  out  1  pending reads or output register occupied

Behaviour:
Reset (reset low, asynchronous):
- mem_req_valid=0; output register fields=0.
- Both pending counters=0.
- RR pointer favours requester 0.
- busy=0 once reset is released.
- A reset asserted mid-operation drops any buffered request and clears all counters; responses in flight after reset are not tracked.

Output register:
- can_load = !mem_req_valid || mem_req_ready.
- A request fired this cycle appears on mem_req_* the next cycle: 1-cycle request latency.
- Back-to-back grants are possible when mem_req_ready=1.

Eligibility:
- eligible[i] = req_valid[i] && (req_rw[i] || pend[i] < MAX_PENDING).
- Writes produce no response and are never throttled.

Arbitration:
- When can_load, grant one eligible requester.
- If both are eligible, grant the one not granted last. The RR pointer updates only on a grant.
- If one is eligible, grant it.
- req_ready[i] = can_load && grant[i]; combinational, and never asserted for a non-eligible requester.
- On grant, load {rw, addr, data, {i, tag}} into the output register.

Pending counters, pend[i], width clog2(MAX_PENDING+1):
- Increment on a granted read from requester i.
- Decrement on a response fire routed to i.
- Increment and decrement in the same cycle leave the count unchanged.
- At MAX_PENDING, requester i's reads stall while its writes proceed.
- A response arriving with pend[i]==0 is an error: simulation assertion fires, the counter holds at 0, and the response is still delivered.

Response path (combinational, no buffering):
- sel = mem_rsp_tag[TAG_WIDTH].
- rsp_valid[sel] = mem_rsp_valid; the other bit = 0.
- rsp_data = mem_rsp_data; rsp_tag = mem_rsp_tag[TAG_WIDTH-1:0].
- mem_rsp_ready = rsp_ready[sel].
- Response backpressure never blocks request issue.

busy = mem_req_valid || pend[0]!=0 || pend[1]!=0.

Test Plan:
- Reset then both requesters issuing reads continuously, mem_req_ready=1 -> grants alternate 0,1,0,1 (requester 0 first); mem_req_tag MSB alternates; 1-cycle latency.
- Requester 0 issues 4 reads, no responses, MAX_PENDING=4 -> 5th read held with req_ready[0]=0 and pend[0]=4; a requester 0 write then passes; one response to requester 0 -> read granted the next cycle.
- mem_req_ready=0 for 3 cycles with the register full -> req_ready=0, mem_req_* stable; on release, the next grant loads in the same cycle.
- Response with tag {1,8'h5A}, rsp_ready[1]=0 then 1 -> rsp_valid=2'b10, mem_rsp_ready follows rsp_ready[1]; pend[1] decrements only on fire.
- Same-cycle grant of a requester 1 read and response to requester 1 -> pend[1] unchanged; busy stays 1.
- Reset asserted with the register full and pend={2,3} -> mem_req_valid=0 and pend={0,0} immediately, without waiting for a clock edge; busy=0.
